// File: rtl/speed_div_scheduler_if.sv
// Request/result bundle between the two speed requesters and the shared divider.
interface speed_div_scheduler_if #(
  parameter int N_W = 16,
  parameter int D_W = 15,
  parameter int Q_W = 7
);
  logic           req0;
  logic [N_W-1:0] num0;
  logic [D_W-1:0] den0;
  logic           ack0;
  logic [Q_W-1:0] q0;
  logic           req1;
  logic [N_W-1:0] num1;
  logic [D_W-1:0] den1;
  logic           ack1;
  logic [Q_W-1:0] q1;
  logic           busy;

  modport master (
    output req0, num0, den0, req1, num1, den1,
    input  ack0, q0, ack1, q1, busy
  );

  modport slave (
    input  req0, num0, den0, req1, num1, den1,
    output ack0, q0, ack1, q1, busy
  );
endinterface

// File: rtl/speed_div_scheduler.sv
// Shared restoring divider for the speed path: arbitrates two requesters and
// returns round(num/den), saturated to the display limit, with a one-cycle ack.
module speed_div_scheduler #(
  parameter int N_W   = 16,
  parameter int D_W   = 15,
  parameter int Q_W   = 7,
  parameter int Q_MAX = 99
) (
  input  logic                clk,
  input  logic                reset,
  speed_div_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  localparam logic [4:0]   LAST_STEP = 5'(N_W);
  localparam logic [N_W:0] SAT_LIM   = (N_W+1)'(Q_MAX);

  function automatic logic [Q_W-1:0] saturate(input logic [N_W:0] x);
    return (x > SAT_LIM) ? Q_W'(Q_MAX) : x[Q_W-1:0];
  endfunction

  state_t         state_q;
  logic           last_grant_q;
  logic           grant_q;
  logic           busy_q;
  logic           ack0_q;
  logic           ack1_q;
  logic [Q_W-1:0] q0_q;
  logic [Q_W-1:0] q1_q;

  logic [N_W:0]   nr_q;
  logic [D_W-1:0] den_q;
  logic [D_W:0]   rem_q;
  logic [N_W-1:0] quot_q;
  logic [4:0]     cnt_q;

  logic [D_W+1:0] trial;
  logic           ge;
  logic [D_W:0]   rem_d;
  logic [N_W:0]   quot_d;
  logic           grant_d;
  logic [N_W-1:0] num_sel;
  logic [D_W-1:0] den_sel;
  logic [N_W:0]   nr_d;
  logic           deliver_d;
  logic [Q_W-1:0] res_d;

  always_comb begin
    trial     = {rem_q, nr_q[N_W]};
    ge        = (trial >= {2'b00, den_q});
    rem_d     = ge ? (D_W+1)'(trial - {2'b00, den_q}) : trial[D_W:0];
    quot_d    = {quot_q, ge};
    grant_d   = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
    num_sel   = grant_q ? bus.num1 : bus.num0;
    den_sel   = grant_q ? bus.den1 : bus.den0;
    nr_d      = {1'b0, num_sel} + (N_W+1)'(den_sel >> 1);
    // Divide path acks on entry to DONE; the zero-divisor path acks from DONE.
    deliver_d = ((state_q == DIV) && (cnt_q == LAST_STEP)) ||
                ((state_q == DONE) && (den_q == '0));
    res_d     = (state_q == DIV) ? saturate(quot_d) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      q0_q         <= '0;
      q1_q         <= '0;
    end else begin
      ack0_q <= deliver_d && !grant_q;
      ack1_q <= deliver_d && grant_q;
      if (deliver_d && !grant_q) q0_q <= res_d;
      if (deliver_d && grant_q)  q1_q <= res_d;
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            busy_q       <= 1'b1;
            state_q      <= LOAD;
          end
        end
        LOAD:    state_q <= (den_sel == '0) ? DONE : DIV;
        DIV:     if (cnt_q == LAST_STEP) state_q <= DONE;
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always reloaded in LOAD.
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      nr_q   <= nr_d;
      den_q  <= den_sel;
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == DIV) begin
      nr_q   <= nr_q << 1;
      rem_q  <= rem_d;
      quot_q <= quot_d[N_W-1:0];
      cnt_q  <= cnt_q + 5'd1;
    end
  end

  assign bus.ack0 = ack0_q;
  assign bus.ack1 = ack1_q;
  assign bus.q0   = q0_q;
  assign bus.q1   = q1_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_speed_div_scheduler.sv
// Randomized and directed bench for speed_div_scheduler against an arithmetic
// model of arbitration, rounding, saturation and latency.
module tb_speed_div_scheduler;
  localparam int N_W = 16;
  localparam int D_W = 15;
  localparam int Q_W = 7;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   lg;
  int   mq0;
  int   mq1;

  speed_div_scheduler_if #(.N_W(N_W), .D_W(D_W), .Q_W(Q_W)) bus ();

  speed_div_scheduler #(.N_W(N_W), .D_W(D_W), .Q_W(Q_W), .Q_MAX(99)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(input int num, input int den);
    int r;
    if (den == 0) return 0;
    r = (num + den / 2) / den;
    return (r > 99) ? 99 : r;
  endfunction

  function automatic int rand_den();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 0;
    if (sel == 1) return 1;
    if (sel == 2) return $urandom_range(1, 32767);
    return $urandom_range(100, 3000);
  endfunction

  // Called just after a negedge; the next posedge is the sampling edge (k=0).
  task automatic txn(input bit r0, input bit r1, input int n0, input int d0,
                     input int n1, input int d1, input bit wiggle, input string tag);
    bit pend0;
    bit pend1;
    int cur;
    int gstart;
    int busy_cnt;
    int exp_busy;
    int tail;
    int p;
    int dd;
    pend0 = r0;
    pend1 = r1;
    bus.num0 = N_W'(n0);
    bus.den0 = D_W'(d0);
    bus.num1 = N_W'(n1);
    bus.den1 = D_W'(d1);
    bus.req0 = r0;
    bus.req1 = r1;
    cur      = (r0 && r1) ? (1 - lg) : (r1 ? 1 : 0);
    lg       = cur;
    gstart   = 0;
    busy_cnt = 0;
    tail     = -1;
    exp_busy = (r0 ? ((d0 == 0) ? 2 : 19) : 0) + (r1 ? ((d1 == 0) ? 2 : 19) : 0);
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      check_eq({tag, " dual_ack"}, int'(bus.ack0 & bus.ack1), 0);
      if (bus.ack0 || bus.ack1) begin
        p  = bus.ack1 ? 1 : 0;
        dd = (cur == 0) ? d0 : d1;
        check_eq({tag, " port"}, p, cur);
        check_eq({tag, " latency"}, k - gstart, (dd == 0) ? 2 : 18);
        if (cur == 0) begin
          mq0 = ref_q(n0, d0);
          pend0 = 1'b0;
          bus.req0 = 1'b0;
        end else begin
          mq1 = ref_q(n1, d1);
          pend1 = 1'b0;
          bus.req1 = 1'b0;
        end
        if (pend0 || pend1) begin
          gstart = k + ((dd == 0) ? 1 : 2);
          cur    = 1 - cur;
          lg     = cur;
        end else begin
          tail = k + 2;
        end
      end
      check_eq({tag, " q0"}, int'(bus.q0), mq0);
      check_eq({tag, " q1"}, int'(bus.q1), mq1);
      if (wiggle && k > gstart) begin
        if (cur == 0 && pend0) begin
          bus.num0 = N_W'($urandom);
          bus.den0 = D_W'($urandom);
        end else if (cur == 1 && pend1) begin
          bus.num1 = N_W'($urandom);
          bus.den1 = D_W'($urandom);
        end
      end
      if (k == tail) break;
    end
    check_eq({tag, " unserved"}, int'(pend0) + int'(pend1), 0);
    check_eq({tag, " busy_cycles"}, busy_cnt, exp_busy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acks;
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.num0 = '0;
    bus.den0 = '0;
    bus.num1 = '0;
    bus.den1 = '0;
    lg  = 1;
    mq0 = 0;
    mq1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst ack0", int'(bus.ack0), 0);
    check_eq("rst ack1", int'(bus.ack1), 0);
    check_eq("rst q0", int'(bus.q0), 0);
    check_eq("rst q1", int'(bus.q1), 0);
    check_eq("rst busy", int'(bus.busy), 0);
    rst = 1'b0;

    txn(1, 1, 14750, 1000, 1500, 1000, 0, "both_after_reset");
    txn(1, 0, 1499, 1000, 0, 0, 0, "round_down");
    txn(1, 1, 1500, 1000, 36875, 100, 0, "both_port1_first");
    txn(1, 0, 14750, 1000, 0, 0, 0, "basic");
    txn(0, 1, 0, 0, 1499, 1000, 0, "round_down_p1");
    txn(0, 1, 0, 0, 1500, 1000, 0, "round_up_p1");
    txn(1, 0, 36875, 100, 0, 0, 0, "saturate");
    txn(1, 0, 500, 0, 0, 0, 0, "den_zero");
    txn(1, 0, 65535, 1, 0, 0, 0, "max_num");
    txn(0, 1, 0, 0, 49, 1, 0, "edge_q49");
    txn(1, 0, 20000, 300, 0, 0, 1, "operand_change");

    bus.num0 = 16'd20000;
    bus.den0 = 15'd300;
    bus.req0 = 1'b1;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    mq0 = 0;
    mq1 = 0;
    lg  = 1;
    check_eq("midrst ack0", int'(bus.ack0), 0);
    check_eq("midrst ack1", int'(bus.ack1), 0);
    check_eq("midrst q0", int'(bus.q0), mq0);
    check_eq("midrst q1", int'(bus.q1), mq1);
    check_eq("midrst busy", int'(bus.busy), 0);
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (25) begin
      @(negedge clk);
      acks += int'(bus.ack0) + int'(bus.ack1);
    end
    check_eq("midrst no_ack", acks, 0);
    txn(1, 0, 14750, 1000, 0, 0, 0, "after_midrst");
    txn(1, 1, 2000, 200, 3000, 200, 0, "both_after_midrst");

    for (int i = 0; i < 24; i++) begin
      bit r0;
      bit r1;
      int n0;
      int d0;
      int n1;
      int d1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      n0 = $urandom_range(0, 65535);
      n1 = $urandom_range(0, 65535);
      d0 = rand_den();
      d1 = rand_den();
      txn(r0, r1, n0, d0, n1, d1, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
